fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Front-end fetch controller that sequences the instruction fetch stage. Owns the architectural fetch PC and issues 32-bit instruction reads to instruction memory. Tracks in-flight reads and buffers returned words in a credit-limited response queue. Presents {pc, instr, valid} to the fetch register, honouring instruction-FIFO backpressure and discarding wrong-path reads on a redirect from the back end.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
MAX_OUTS, 2, credits: max (in-flight reads + queued responses); power of 2, 2..8

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  synchronous active-low reset, sampled on rising CLK
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  64  request address, word aligned
imem_rsp_valid  input  1  read data returned; in request order; at most one per cycle; never before the accepting cycle +1
imem_rsp_data  input  32  returned instruction word
instr_readout  output  32  queue head instruction to fetch register
pc_in  output  64  queue head PC to fetch register
isInstrReadOut  output  1  head valid; fetch register captures when isInstrReadOut & ~instrFifo_full
instrFifo_full  input  1  downstream instruction FIFO full
redirect_valid  input  1  flush and restart fetch (branch/jump/trap)
redirect_pc  input  64  new fetch PC; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (RSTn=0 at edge):
  - fetch_pc=RESET_PC, inflight=0, queue empty, kill=0, state=BOOT.
  - Outputs: imem_req_valid=0, isInstrReadOut=0, imem_addr=RESET_PC, instr_readout=0, pc_in=0.
  - Reset mid-operation abandons all state; later responses to pre-reset requests are the memory's responsibility (the memory is reset together with this block).
- States: BOOT, FETCH, FLUSH.
  - BOOT: one cycle, no request; then FETCH.
  - FETCH: imem_req_valid=1 iff (inflight + q_count) < MAX_OUTS. imem_addr=fetch_pc. On valid&ready: fetch_pc+=4 (64-bit wrap, no trap), inflight+=1, request PC pushed to a PC-tag FIFO (depth MAX_OUTS).
  - FLUSH: entered on redirect_valid while inflight≠0 after this cycle; kill=inflight; no requests; each imem_rsp_valid decrements inflight and kill, and the data is dropped. Return to FETCH the cycle after kill reaches 0.
  - Redirect with inflight==0 goes straight to FETCH with the new PC; the first new request appears the next cycle.
- Redirect (any state, highest priority):
  - fetch_pc<=redirect_pc&~3. Response queue cleared.
  - isInstrReadOut forced 0 in the redirect cycle.
  - Any request handshake in the redirect cycle is counted in kill.
  - A response arriving in the redirect cycle is dropped and not counted in kill.
  - Redirect during FLUSH reloads fetch_pc; kill stays equal to inflight.
- Response path:
  - Non-killed response: {tag PC, data} pushed to the response queue (depth MAX_OUTS). The credit rule guarantees no overflow.
  - isInstrReadOut = q_count≠0 & ~instrFifo_full & ~redirect_valid. instr_readout/pc_in = queue head (combinational). Pop when isInstrReadOut.
  - Simultaneous push and pop keeps q_count; a free credit is visible the next cycle.
- Latency: reset release → first request 2 cycles after; response at cycle t → isInstrReadOut at t+1 if the FIFO is not full.
- instrFifo_full held high: requests stop once credits are exhausted; no data lost.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_req_cnt[31:0] (accepted requests) and perf_kill_cnt[31:0] (dropped responses). Both reset to 0, wrap at 2^32, increment at most 1 per cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, 1-cycle-latency memory, FIFO never full → requests 0x80000000, 0x80000004, 0x80000008…; isInstrReadOut pulses with matching pc_in, one per cycle in steady state.
- instrFifo_full=1 for 10 cycles with MAX_OUTS=2 → exactly 2 requests accepted, isInstrReadOut=0; release → queued PCs emitted in order, no gap or duplicate.
- imem_req_ready=0 for 5 cycles → imem_addr holds at the same value, fetch_pc unchanged, no response expected.
- redirect_valid, redirect_pc=0x80001002 with 2 in flight → 2 responses dropped (perf_kill_cnt=2 when the macro is defined), next request addr 0x80001000, first delivered pc_in=0x80001000.
- Redirect coinciding with a response and a request handshake → response dropped, handshake counted in kill, no wrong-path instruction delivered.
- RSTn=0 for 1 cycle mid-stream → next-cycle outputs at reset values; fetch resumes at RESET_PC after BOOT.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end fetch controller that owns the fetch PC, issues
// credit-limited instruction reads and delivers {pc, instr} to the fetch register.
//
// Ports:
//   CLK, RSTn            clock (rising edge) and synchronous active-low reset
//   imem_req_*, imem_addr     read request channel to instruction memory
//   imem_rsp_*                in-order read data returned from memory
//   instr_readout, pc_in, isInstrReadOut   queue head presented to the fetch register
//   instrFifo_full            downstream backpressure
//   redirect_valid/_pc        flush and restart fetch at a new PC
//   perf_req_cnt, perf_kill_cnt   accepted requests / dropped responses
//                                 (present only with FETCH_PERF_CNT_EN defined)
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          MAX_OUTS = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr_readout,
    output logic [63:0] pc_in,
    output logic        isInstrReadOut,
    input  logic        instrFifo_full,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);
    localparam int PW = $clog2(MAX_OUTS);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

    state_t        state, state_nx;
    logic [63:0]   fetch_pc;
    logic [CW-1:0] inflight, inflight_nx, kill, kill_nx, q_count;
    logic [PW-1:0] t_wr, t_rd, q_wr, q_rd;
    logic [63:0]   tag_pc [MAX_OUTS];
    logic [63:0]   q_pc   [MAX_OUTS];
    logic [31:0]   q_data [MAX_OUTS];
    logic          req_fire, rsp_keep, pop;

    // A request needs a credit: every in-flight read must have a queue slot waiting.
    assign imem_req_valid = (state == FETCH) &&
                            (({1'b0, inflight} + {1'b0, q_count}) < (CW+1)'(MAX_OUTS));
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign isInstrReadOut = (q_count != '0) & ~instrFifo_full & ~redirect_valid;
    assign pop            = isInstrReadOut;
    // Responses are dropped in the redirect cycle and while wrong-path reads drain.
    assign rsp_keep       = imem_rsp_valid & ~redirect_valid & (kill == '0);
    assign instr_readout  = (q_count != '0) ? q_data[q_rd] : 32'd0;
    assign pc_in          = (q_count != '0) ? q_pc[q_rd] : 64'd0;

    always_comb begin
        inflight_nx = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
        // On redirect every read still outstanding after this cycle is wrong-path.
        kill_nx     = redirect_valid ? inflight_nx
                                     : kill - CW'(imem_rsp_valid && (kill != '0));
        state_nx    = redirect_valid ? ((inflight_nx != '0) ? FLUSH : FETCH)
                    : (state == BOOT || (state == FLUSH && kill_nx == '0)) ? FETCH
                    : state;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            kill     <= '0;
            q_count  <= '0;
            t_wr     <= '0;
            t_rd     <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
        end else begin
            state    <= state_nx;
            inflight <= inflight_nx;
            kill     <= kill_nx;
            fetch_pc <= redirect_valid ? (redirect_pc & ~64'd3)
                      : req_fire ? fetch_pc + 64'd4 : fetch_pc;
            t_wr     <= t_wr + PW'(req_fire);
            // The tag FIFO mirrors every outstanding read, killed or not.
            t_rd     <= t_rd + PW'(imem_rsp_valid);
            if (redirect_valid) begin
                q_count <= '0;
                q_wr    <= '0;
                q_rd    <= '0;
            end else begin
                q_count <= q_count + CW'(rsp_keep) - CW'(pop);
                q_wr    <= q_wr + PW'(rsp_keep);
                q_rd    <= q_rd + PW'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (req_fire)
            tag_pc[t_wr] <= fetch_pc;
        if (rsp_keep) begin
            q_pc[q_wr]   <= tag_pc[t_rd];
            q_data[q_wr] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            perf_req_cnt  <= '0;
            perf_kill_cnt <= '0;
        end else begin
            perf_req_cnt  <= perf_req_cnt + 32'(req_fire);
            perf_kill_cnt <= perf_kill_cnt + 32'(imem_rsp_valid & ~rsp_keep);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench for fetch_sequencer with an in-order memory model.
module tb_fetch_sequencer;
    localparam int          MAX_OUTS = 2;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic [31:0] instr_readout;
    logic [63:0] pc_in;
    logic        isInstrReadOut;
    logic        instrFifo_full = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_req_cnt, perf_kill_cnt;
`endif

    fetch_sequencer #(.RESET_PC(RESET_PC), .MAX_OUTS(MAX_OUTS)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_readout(instr_readout), .pc_in(pc_in), .isInstrReadOut(isInstrReadOut),
        .instrFifo_full(instrFifo_full), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_req_cnt(perf_req_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [63:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;

    req_t        pend[$];
    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, epoch = 0, since_rst = 0, hs_total = 0, kill_total = 0;
    int          lat_min = 1, lat_max = 1;
    logic [63:0] model_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor, memory model and scoreboard: everything observed mid-cycle.
    always @(negedge CLK) begin
        int   n_out, n_q;
        exp_t e;
        req_t p;
        n_out = pend.size();
        n_q   = sb.size();
        if (!RSTn) begin
            pend.delete();
            sb.delete();
            epoch++;
            model_pc   = RESET_PC;
            since_rst  = 0;
            hs_total   = 0;
            kill_total = 0;
        end else begin
            if (since_rst == 0) begin
                chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
                chk("rst_out_valid", 64'(isInstrReadOut), 64'd0);
                chk("rst_addr", imem_addr, RESET_PC);
                chk("rst_instr", 64'(instr_readout), 64'd0);
                chk("rst_pc", pc_in, 64'd0);
            end
            if (since_rst == 1)
                chk("first_req", 64'(imem_req_valid), 64'd1);
            if (since_rst < 100)
                since_rst++;
            chk("addr", imem_addr, model_pc);
            chk("out_valid", 64'(isInstrReadOut),
                64'(n_q != 0 && !instrFifo_full && !redirect_valid));
            if (isInstrReadOut && sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", pc_in, e.pc);
                chk("out_instr", 64'(instr_readout), 64'(e.ins));
            end
            if (imem_rsp_valid && pend.size() != 0) begin
                p = pend.pop_front();
                if (redirect_valid || p.epoch != epoch)
                    kill_total++;
                else
                    sb.push_back('{pc: p.addr, ins: mem_word(p.addr)});
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("credit", 64'(n_out + n_q < MAX_OUTS), 64'd1);
                pend.push_back('{addr: imem_addr, epoch: epoch,
                                 due: cyc + $urandom_range(lat_max, lat_min)});
                model_pc = model_pc + 64'd4;
                hs_total++;
            end
            if (redirect_valid) begin
                model_pc = redirect_pc & ~64'd3;
                sb.delete();
                epoch++;
            end
        end
        cyc++;
    end

    task automatic drive(input logic rdy, input logic fl, input logic rd,
                         input logic [63:0] rp, input logic rn);
        @(posedge CLK);
        #1;
        RSTn           = rn;
        imem_req_ready = rdy;
        instrFifo_full = fl;
        redirect_valid = rd && since_rst > 3;
        redirect_pc    = rp;
        if (rn && pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (pend.size() != 0 || sb.size() != 0); i++)
            drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("drain", 64'(pend.size() + sb.size()), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_req", 64'(perf_req_cnt), 64'(hs_total));
        chk("perf_kill", 64'(perf_kill_cnt), 64'(kill_total));
`endif
    endtask

    initial begin
        int mark;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        lat_min = 1; lat_max = 1;
        repeat (20) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        drain();
        mark = hs_total;
        repeat (10) drive(1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
        chk("full_reqs", 64'(hs_total - mark), 64'(MAX_OUTS));
        repeat (10) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        drain();
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 20 && pend.size() < 2; i++)
            drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("two_inflight", 64'(pend.size()), 64'd2);
        drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_1002, 1'b1);
        lat_min = 1; lat_max = 1;
        repeat (15) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        drain();
        repeat (10) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        drain();
        repeat (1500) begin
            lat_max = $urandom_range(4, 1);
            drive($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 2,
                  $urandom_range(29, 0) == 0, {$urandom, $urandom},
                  $urandom_range(199, 0) != 0);
        end
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
